floo_id_translation_seq: RTL and testbench

FLOO_ID_TRANSLATION_SEQ -- requirements
Module: floo_id_translation_seq

---
 rtl/floo_pkg.sv | 34 +++
 rtl/floo_id_cache.sv | 89 ++++++++
 rtl/floo_id_translation_seq.sv | 193 +++++++++++++++++++
 tb/tb_floo_id_translation_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// floo_pkg: shared types for the sequential ID translation block.
//   - default address / id / mask-select types
//   - floo_idx_t / floo_addr_rule_t: one system-address-map rule
//   - floo_xlat_state_e: translation FSM state, also exported on a debug port
package floo_pkg;

  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned MaskSelWidth = 3;

  typedef logic [AddrWidth-1:0]    floo_addr_t;
  typedef logic [IdWidth-1:0]      floo_id_t;
  typedef logic [MaskSelWidth-1:0] floo_mask_sel_t;

  typedef struct packed {
    floo_id_t       id;
    floo_mask_sel_t mask_x;
    floo_mask_sel_t mask_y;
  } floo_idx_t;

  // A rule covers [start_addr, end_addr), compared unsigned.
  typedef struct packed {
    floo_idx_t  idx;
    floo_addr_t start_addr;
    floo_addr_t end_addr;
  } floo_addr_rule_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } floo_xlat_state_e;

endpackage

// File: rtl/floo_id_cache.sv
// floo_id_cache: small fully associative translation cache.
//   clk_i, rst_ni    clock, synchronous active-low reset
//   flush_i          clear every valid bit this cycle (wins over a fill)
//   lookup_tag_i     combinational lookup -> hit_o, hit_data_o
//   fill_i           write fill_tag_i/fill_data_i into the first invalid entry,
//                    else into the round-robin victim, which then advances
// The owner only fills after a miss on the same tag with no fill in between,
// so a tag is never present twice.
module floo_id_cache #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned TagWidth   = 20,
  parameter int unsigned DataWidth  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [TagWidth-1:0]  lookup_tag_i,
  output logic                 hit_o,
  output logic [DataWidth-1:0] hit_data_o,
  input  logic                 fill_i,
  input  logic [TagWidth-1:0]  fill_tag_i,
  input  logic [DataWidth-1:0] fill_data_i
);

  localparam int unsigned IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumEntries - 1);

  logic [NumEntries-1:0] valid_q;
  logic [TagWidth-1:0]   tag_q  [NumEntries];
  logic [DataWidth-1:0]  data_q [NumEntries];
  logic [IdxWidth-1:0]   victim_q;

  logic                  has_free;
  logic [IdxWidth-1:0]   free_idx;
  logic [IdxWidth-1:0]   fill_idx;
  logic                  do_fill;

  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (!hit_o && valid_q[IdxWidth'(i)] && (tag_q[IdxWidth'(i)] == lookup_tag_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[IdxWidth'(i)];
      end
    end
  end

  // Lowest-numbered invalid entry takes the fill; the victim pointer is only
  // consulted (and advanced) once the cache is full.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (!has_free && !valid_q[IdxWidth'(i)]) begin
        has_free = 1'b1;
        free_idx = IdxWidth'(i);
      end
    end
  end

  assign fill_idx = has_free ? free_idx : victim_q;
  assign do_fill  = fill_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= '0;
      end else if (do_fill) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (do_fill && !has_free) begin
        victim_q <= (victim_q == LastIdx) ? '0 : victim_q + IdxWidth'(1);
      end
    end
  end

  // Tag/data storage needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (do_fill) begin
      tag_q[fill_idx]  <= fill_tag_i;
      data_q[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/floo_id_translation_seq.sv
// floo_id_translation_seq: translates an address into a destination id and
// mask selectors by scanning a system address map RulesPerCycle rules per
// cycle, with a page-granular translation cache in front of the scan.
//   clk_i, rst_ni               clock, synchronous active-low reset
//   flush_i                     invalidate the cache (in-flight work continues)
//   sam_i                       address map, quasi-static
//   req_valid_i/req_ready_o     request, req_addr_i
//   rsp_valid_o/rsp_ready_i     response, rsp_id_o, rsp_mask_x_o/y_o, rsp_error_o
//   dbg_state_o                 FSM state
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. req_ready_o is high only in IDLE. Once rsp_valid_o rises, it and
// every rsp_* output hold until the edge where rsp_ready_i is seen high.
module floo_id_translation_seq
  import floo_pkg::*;
#(
  parameter int unsigned NumRules        = 8,
  parameter int unsigned RulesPerCycle   = 2,
  parameter int unsigned NumCacheEntries = 4,
  parameter int unsigned PageShift       = 12,
  parameter type addr_t      = floo_addr_t,
  parameter type id_t        = floo_id_t,
  parameter type mask_sel_t  = floo_mask_sel_t,
  parameter type addr_rule_t = floo_addr_rule_t
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  addr_rule_t       sam_i [NumRules],
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  addr_t            req_addr_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output id_t              rsp_id_o,
  output mask_sel_t        rsp_mask_x_o,
  output mask_sel_t        rsp_mask_y_o,
  output logic             rsp_error_o,
  output floo_xlat_state_e dbg_state_o
);

  localparam int unsigned AddrWidth    = $bits(addr_t);
  localparam int unsigned TagWidth     = AddrWidth - PageShift;
  localparam int unsigned DataWidth    = $bits(id_t) + 2 * $bits(mask_sel_t);
  localparam int unsigned NumBeats     = (NumRules + RulesPerCycle - 1) / RulesPerCycle;
  localparam int unsigned BeatWidth    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned RuleIdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(NumBeats - 1);

  floo_xlat_state_e       state_q, state_d;
  logic [BeatWidth-1:0]   beat_q, beat_d;
  addr_t                  addr_q;
  logic                   fill_block_q;
  logic [DataWidth-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   load_rsp;
  logic                   accept;

  logic                   cache_hit;
  logic [DataWidth-1:0]   cache_data;
  logic                   cache_fill;

  logic                   scan_match;
  logic [DataWidth-1:0]   scan_data;
  logic [RuleIdxWidth-1:0] rule_idx;
  int unsigned            flat_idx;

  assign accept = (state_q == IDLE) && req_valid_i;

  floo_id_cache #(
    .NumEntries (NumCacheEntries),
    .TagWidth   (TagWidth),
    .DataWidth  (DataWidth)
  ) i_cache (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .lookup_tag_i (req_addr_i[AddrWidth-1:PageShift]),
    .hit_o        (cache_hit),
    .hit_data_o   (cache_data),
    .fill_i       (cache_fill),
    .fill_tag_i   (addr_q[AddrWidth-1:PageShift]),
    .fill_data_i  (scan_data)
  );

  // One beat compares rules beat*RulesPerCycle .. +RulesPerCycle-1, clipped at
  // the end of the map. Ascending order makes the lowest rule index win.
  always_comb begin
    scan_match = 1'b0;
    scan_data  = '0;
    rule_idx   = '0;
    flat_idx   = 0;
    for (int j = 0; j < RulesPerCycle; j++) begin
      flat_idx = 32'(beat_q) * RulesPerCycle + 32'(j);
      if (flat_idx < NumRules) begin
        rule_idx = RuleIdxWidth'(flat_idx);
        if (!scan_match && (addr_q >= sam_i[rule_idx].start_addr) &&
            (addr_q < sam_i[rule_idx].end_addr)) begin
          scan_match = 1'b1;
          scan_data  = {sam_i[rule_idx].idx.id, sam_i[rule_idx].idx.mask_x,
                        sam_i[rule_idx].idx.mask_y};
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    load_rsp    = 1'b0;
    rsp_data_d  = '0;
    rsp_error_d = 1'b0;
    cache_fill  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          beat_d = '0;
          if (cache_hit) begin
            state_d    = RESP;
            load_rsp   = 1'b1;
            rsp_data_d = cache_data;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan_match) begin
          state_d    = RESP;
          load_rsp   = 1'b1;
          rsp_data_d = scan_data;
          cache_fill = !fill_block_q;
        end else if (beat_q == LastBeat) begin
          state_d     = RESP;
          load_rsp    = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          beat_d = beat_q + BeatWidth'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // fill_block_q remembers a flush seen while this translation was in flight,
  // so its result is returned but not cached.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      addr_q       <= '0;
      fill_block_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        addr_q       <= req_addr_i;
        fill_block_q <= flush_i;
      end else if ((state_q == SCAN) && flush_i) begin
        fill_block_q <= 1'b1;
      end
      if (load_rsp) begin
        rsp_data_q  <= rsp_data_d;
        rsp_error_q <= rsp_error_d;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign rsp_valid_o = rst_ni && (state_q == RESP);
  assign {rsp_id_o, rsp_mask_x_o, rsp_mask_y_o} = rst_ni ? rsp_data_q : '0;
  assign rsp_error_o = rst_ni && rsp_error_q;
  assign dbg_state_o = state_q;

  // Rules must sit on page boundaries, otherwise a cached page could span
  // two rules.
  for (genvar g = 0; g < NumRules; g++) begin : gen_align_chk
    always_ff @(posedge clk_i) begin
      if (rst_ni) begin
        assert ((sam_i[g].start_addr[PageShift-1:0] == '0) &&
                (sam_i[g].end_addr[PageShift-1:0] == '0));
      end
    end
  end

endmodule

// File: tb/tb_floo_id_translation_seq.sv
module tb_floo_id_translation_seq;
  import floo_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  floo_addr_t       req_addr = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  floo_id_t         rsp_id;
  floo_mask_sel_t   rsp_mx, rsp_my;
  logic             rsp_error;
  floo_xlat_state_e dbg_state;
  floo_addr_rule_t  sam [8];

  floo_id_translation_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .sam_i        (sam),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_mask_x_o (rsp_mx),
    .rsp_mask_y_o (rsp_my),
    .rsp_error_o  (rsp_error),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Rule i: id = i+1, mask_x = (i+1) mod 8, mask_y = i.
  task automatic set_rule(input int i, input logic [31:0] s, input logic [31:0] e);
    sam[i].idx.id     = 4'(i + 1);
    sam[i].idx.mask_x = 3'(i + 1);
    sam[i].idx.mask_y = 3'(i);
    sam[i].start_addr = s;
    sam[i].end_addr   = e;
  endtask

  // ---------------- driver ----------------
  // Issues one request, measures cycles from acceptance to rsp_valid,
  // optionally pulses flush in the first scan cycle and stalls rsp_ready.
  task automatic run_req(input string name, input logic [31:0] addr, input int exp_lat,
                         input logic err, input logic [3:0] id, input logic [2:0] mx,
                         input logic [2:0] my, input int stall, input bit flush_mid);
    int n;
    int lat;
    bit stable;
    logic [10:0] got, exp_rsp;
    exp_q.push_back({err, id, mx, my});
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_accept"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (flush_mid) flush = 1'b1;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      flush = 1'b0;
      lat++;
    end
    flush = 1'b0;
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    got = {rsp_error, rsp_id, rsp_mx, rsp_my};
    exp_rsp = exp_q.pop_front();
    chk({name, "_rsp"}, 32'(got), 32'(exp_rsp));
    if (stall > 0) begin
      stable = 1'b1;
      for (int c = 0; c < stall; c++) begin
        @(posedge clk);
        #1;
        if (!rsp_valid || req_ready || ({rsp_error, rsp_id, rsp_mx, rsp_my} != got))
          stable = 1'b0;
      end
      chk({name, "_stall"}, 32'(stable), 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({name, "_idle"}, {29'd0, dbg_state == IDLE, req_ready, rsp_valid}, 32'b110);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic        err;
    logic [3:0]  id;
    logic [2:0]  mx;
    logic [2:0]  my;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit seen;

    set_rule(0, 32'h0000_1000, 32'h0000_3000);
    set_rule(1, 32'h0000_4000, 32'h0000_6000);
    set_rule(2, 32'h0000_8000, 32'h0000_9000);
    set_rule(3, 32'h0000_3000, 32'h0000_5000);  // overlaps rule 1 at 0x4000
    set_rule(4, 32'h0001_0000, 32'h0001_4000);
    set_rule(5, 32'h0002_0000, 32'h0002_8000);
    set_rule(6, 32'h0003_0000, 32'h0003_1000);
    set_rule(7, 32'h0004_0000, 32'h0005_0000);

    // Applied in order from a cold cache; the cache contents follow the list.
    vecs[0]  = '{32'h0002_0100, 4, 1'b0, 4'd6, 3'd6, 3'd5};  // rule 5 cold: 3 beats + 1
    vecs[1]  = '{32'h0002_0ABC, 1, 1'b0, 4'd6, 3'd6, 3'd5};  // same page: hit
    vecs[2]  = '{32'h0009_0000, 5, 1'b1, 4'd0, 3'd0, 3'd0};  // unmapped
    vecs[3]  = '{32'h0009_0010, 5, 1'b1, 4'd0, 3'd0, 3'd0};  // unmapped again, not cached
    vecs[4]  = '{32'h0000_4000, 2, 1'b0, 4'd2, 3'd2, 3'd1};  // overlap: rule 1 wins
    vecs[5]  = '{32'h0000_3000, 3, 1'b0, 4'd4, 3'd4, 3'd3};  // rule 0 end exclusive -> rule 3
    vecs[6]  = '{32'h0004_8000, 5, 1'b0, 4'd8, 3'd0, 3'd7};  // last rule, last beat
    vecs[7]  = '{32'h0000_1FFF, 2, 1'b0, 4'd1, 3'd1, 3'd0};  // 5th page: evicts page 0x20
    vecs[8]  = '{32'h0002_0000, 4, 1'b0, 4'd6, 3'd6, 3'd5};  // first page again: miss
    vecs[9]  = '{32'h0000_3FFF, 1, 1'b0, 4'd4, 3'd4, 3'd3};  // page 0x3 still cached
    vecs[10] = '{32'h0000_6000, 5, 1'b1, 4'd0, 3'd0, 3'd0};  // rule 1 end exclusive
    vecs[11] = '{32'h0000_0FFF, 5, 1'b1, 4'd0, 3'd0, 3'd0};  // just below rule 0

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_out", {21'd0, rsp_error, rsp_id, rsp_mx, rsp_my}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].err,
              vecs[i].id, vecs[i].mx, vecs[i].my, 0, 1'b0);
    end

    // Response back-pressure for 10 cycles on a cache hit
    run_req("stall", 32'h0000_3000, 1, 1'b0, 4'd4, 3'd4, 3'd3, 10, 1'b0);

    // Flush while idle: a previously cached page misses
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run_req("flush_idle", 32'h0000_3000, 3, 1'b0, 4'd4, 3'd4, 3'd3, 0, 1'b0);

    // Flush during a scan: response still delivered, result not cached
    run_req("flush_scan", 32'h0004_0000, 5, 1'b0, 4'd8, 3'd0, 3'd7, 0, 1'b1);
    run_req("flush_scan_rep", 32'h0004_0000, 5, 1'b0, 4'd8, 3'd0, 3'd7, 0, 1'b0);
    run_req("flush_scan_hit", 32'h0004_0004, 1, 1'b0, 4'd8, 3'd0, 3'd7, 0, 1'b0);

    // Reset in the middle of a scan drops the transaction
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0009_0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_scan_state", 32'(dbg_state), 32'(SCAN));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_scan_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_scan_valid", 32'(rsp_valid), 32'd0);
    chk("rst_scan_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_scan_no_rsp", 32'(seen), 32'd0);
    chk("rst_scan_ready_after", 32'(req_ready), 32'd1);

    // Reset invalidated the cache: the page cached above misses again
    run_req("post_rst_miss", 32'h0004_0004, 5, 1'b0, 4'd8, 3'd0, 3'd7, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
